// File: rtl/op2_stage_pkg.sv
// ============================================================================
// Module      : op2_pkg (package)
// Description : Shared constants and types for the operand2 pipeline stage:
//               shifter type codes, A32 data-processing field positions and
//               the registered payload bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package op2_pkg;

    // Shifter type encodings
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // A32 data-processing instruction field positions (LSB of each field)
    localparam int BIT_I     = 25;  // immediate operand2 select
    localparam int BIT_S     = 20;  // set-flags
    localparam int OPC_LSB   = 21;  // opcode [24:21]
    localparam int RD_LSB    = 12;  // Rd [15:12]
    localparam int ROT_LSB   = 8;   // rotate [11:8]
    localparam int IMM8_LSB  = 0;   // imm8 [7:0]
    localparam int IMM5_LSB  = 7;   // shift amount [11:7]
    localparam int TYPE_LSB  = 5;   // shift type [6:5]
    localparam int BIT_REGSH = 4;   // 1 = shift amount taken from a register

    // Registered bundle handed to the shifter/ALU
    typedef struct packed {
        logic [31:0] sh_data;
        logic [4:0]  sh_amt;
        logic [1:0]  sh_type;
        logic        is_imm;
        logic        illegal;
        logic [3:0]  rd;
        logic [3:0]  opcode;
        logic        s;
    } op2_payload_t;

    localparam int PAYLOAD_W = $bits(op2_payload_t);

endpackage

`default_nettype wire

// File: rtl/op2_stage_if.sv
// ============================================================================
// Module      : op2_stage_if (interface)
// Description : Upstream valid/ready instruction bus plus downstream
//               valid/ready shifter/ALU payload bus of the operand2 stage.
//               master : upstream/downstream environment view
//               slave  : the op2_stage view
// Ports       : in_valid/in_ready/in_instr/in_rm_val (decode side),
//               out_valid/out_ready/sh_*/out_* (execute side)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface op2_stage_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instr;
    logic [DW-1:0] in_rm_val;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sh_data;
    logic [4:0]    sh_amt;
    logic [1:0]    sh_type;
    logic          out_is_imm;
    logic          out_illegal;
    logic [3:0]    out_rd;
    logic [3:0]    out_opcode;
    logic          out_s;

    modport master (
        output in_valid, in_instr, in_rm_val, out_ready,
        input  in_ready, out_valid, sh_data, sh_amt, sh_type,
               out_is_imm, out_illegal, out_rd, out_opcode, out_s
    );

    modport slave (
        input  in_valid, in_instr, in_rm_val, out_ready,
        output in_ready, out_valid, sh_data, sh_amt, sh_type,
               out_is_imm, out_illegal, out_rd, out_opcode, out_s
    );
endinterface

`default_nettype wire

// File: rtl/op2_stage_decode.sv
// ============================================================================
// Module      : op2_decode
// Description : Purely combinational operand2 resolver. Maps an A32
//               data-processing instruction and its Rm value onto shifter
//               controls. Immediates become ROR so one shifter serves both.
// Ports       : instr_i   - instruction word
//               rm_val_i  - Rm register value
//               payload_o - decoded payload bundle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op2_decode
    import op2_pkg::*;
(
    input  wire logic [31:0]  instr_i,
    input  wire logic [31:0]  rm_val_i,
    output op2_payload_t      payload_o
);

    // Condition field and Rn are consumed elsewhere in the pipeline
    logic w_unused;
    assign w_unused = ^{instr_i[31:26], instr_i[19:16]};

    always_comb begin
        payload_o         = '0;
        payload_o.rd      = instr_i[RD_LSB +: 4];
        payload_o.opcode  = instr_i[OPC_LSB +: 4];
        payload_o.s       = instr_i[BIT_S];
        if (instr_i[BIT_I]) begin
            // rotate field counts in steps of two bit positions
            payload_o.sh_data = {24'b0, instr_i[IMM8_LSB +: 8]};
            payload_o.sh_amt  = {instr_i[ROT_LSB +: 4], 1'b0};
            payload_o.sh_type = SH_ROR;
            payload_o.is_imm  = 1'b1;
        end else if (instr_i[BIT_REGSH]) begin
            // register-specified shift is not supported by this core
            payload_o.sh_data = rm_val_i;
            payload_o.sh_amt  = 5'd0;
            payload_o.sh_type = SH_LSL;
            payload_o.illegal = 1'b1;
        end else begin
            payload_o.sh_data = rm_val_i;
            payload_o.sh_amt  = instr_i[IMM5_LSB +: 5];
            payload_o.sh_type = instr_i[TYPE_LSB +: 2];
        end
    end

endmodule

`default_nettype wire

// File: rtl/op2_stage.sv
// ============================================================================
// Module      : op2_stage
// Description : Pipeline stage between decode/register-read and execute.
//               Decodes operand2 and registers the shifter controls together
//               with Rd/opcode/S behind a valid/ready handshake.
//               Build macro OP2_SKID_EN: adds a skid entry so that in_ready
//               is a pure register output (no out_ready -> in_ready path).
//               Without it the stage holds a single entry.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               flush - synchronous flush, drops all held entries
//               bus   - op2_stage_if slave modport (handshakes + payload)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op2_stage
    import op2_pkg::*;
#(
    parameter int DW = 32
)(
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  flush,
    op2_stage_if.slave bus
);

    logic [DW-1:0] w_rm_val;
    op2_payload_t  w_dec;
    logic          w_in_ready;
    logic          w_in_xfer;

    logic          main_valid_q, main_valid_d;
    op2_payload_t  main_q, main_d;

    assign w_rm_val = bus.in_rm_val;

    op2_decode u_decode (
        .instr_i   (bus.in_instr),
        .rm_val_i  (w_rm_val),
        .payload_o (w_dec)
    );

`ifdef OP2_SKID_EN
    logic          skid_valid_q, skid_valid_d;
    op2_payload_t  skid_q, skid_d;

    assign w_in_ready = !skid_valid_q;
`else
    assign w_in_ready = !main_valid_q || bus.out_ready;
`endif

    assign w_in_xfer = bus.in_valid && w_in_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
`ifdef OP2_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
`endif
        if (flush) begin
            // payload contents are left in place; only the valids drop
            main_valid_d = 1'b0;
`ifdef OP2_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end else begin
`ifdef OP2_SKID_EN
            if (skid_valid_q) begin
                // upstream is blocked; skid advances once main departs
                if (bus.out_ready) begin
                    main_d       = skid_q;
                    skid_valid_d = 1'b0;
                end
            end else if (main_valid_q && !bus.out_ready) begin
                if (w_in_xfer) begin
                    skid_d       = w_dec;
                    skid_valid_d = 1'b1;
                end
            end else begin
                // main is empty or departing: refill directly, no bubble
                main_valid_d = w_in_xfer;
                if (w_in_xfer) begin
                    main_d = w_dec;
                end
            end
`else
            if (w_in_xfer) begin
                main_valid_d = 1'b1;
                main_d       = w_dec;
            end else if (bus.out_ready) begin
                main_valid_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
`ifdef OP2_SKID_EN
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
`endif
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
`ifdef OP2_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
`endif
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = main_valid_q;
    assign bus.sh_data     = main_q.sh_data;
    assign bus.sh_amt      = main_q.sh_amt;
    assign bus.sh_type     = main_q.sh_type;
    assign bus.out_is_imm  = main_q.is_imm;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_s       = main_q.s;

endmodule

`default_nettype wire

// File: doc/op2_stage.md
Name: op2_stage

Overview:
- Pipeline stage between decode/register-read and execute in the A32 MCU core.
- Accepts one data-processing instruction plus the Rm read value per handshake.
- Resolves operand2 into shifter controls (data, amount, type), registers them with Rd/opcode/S, and presents them to the downstream barrel shifter and ALU.
- Immediate operands are mapped onto ROR, so the shifter handles both operand forms uniformly.

Parameters:
- DW, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (branch taken)
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  A32 instruction word
- in_rm_val  in  DW  register-file value of Rm
- out_valid  out  1  registered payload valid
- out_ready  in  1  downstream accepts
- sh_data  out  DW  shifter data input
- sh_amt  out  5  shifter amount
- sh_type  out  2  00 LSL | 01 LSR | 10 ASR | 11 ROR
- out_is_imm  out  1  operand2 was immediate
- out_illegal  out  1  register-specified shift (unsupported)
- out_rd  out  4  instr[15:12]
- out_opcode  out  4  instr[24:21]
- out_s  out  1  instr[20]

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0 and all payload outputs=0. in_ready=1 from the first cycle after reset release.
- Decode (combinational on inputs, captured on transfer):
  - instr[25]=1: sh_data={24'b0,instr[7:0]}, sh_amt={instr[11:8],1'b0}, sh_type=11, is_imm=1. rot=0 yields ROR #0, i.e. passthrough.
  - instr[25]=0, instr[4]=0: sh_data=in_rm_val, sh_amt=instr[11:7], sh_type=instr[6:5], is_imm=0.
  - instr[25]=0, instr[4]=1: illegal=1, sh_data=in_rm_val, sh_amt=0, sh_type=00.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction per cycle while out_ready=1.
- While out_valid=1 && out_ready=0, every payload output holds stable.
- in_valid may drop without a transfer; the stage ignores input fields whenever in_valid=0.
- Flush:
  - Next cycle: out_valid=0 and all held entries are dropped.
  - An input transfer in the same cycle as flush is discarded.
  - in_ready=1 the cycle after flush.
  - Payload registers keep their contents; they are don't-care while out_valid=0.
- Simultaneous input and output transfers: the new entry replaces the departing one with no bubble.
- Order is strictly preserved.

Optional Feature:
- OP2_SKID_EN defined:
  - Two entries: main plus skid.
  - in_ready is a pure register output, equal to !skid_valid.
  - An input transfer while main is stalled fills skid; in_ready drops the next cycle.
  - On out_ready, skid moves to main and in_ready returns to 1 the next cycle.
  - No combinational path from out_ready to in_ready.
- Undefined:
  - Single entry.
  - in_ready = !out_valid || out_ready (combinational).

Decomposition:
- Package op2_pkg holds:
  - SH_LSL/SH_LSR/SH_ASR/SH_ROR 2-bit constants.
  - Instruction field bit positions (I, S, opcode, Rd, imm8, rot, imm5, type, bit4).
  - Payload width constant for the registered bundle.
- One sub-module, op2_decode: purely combinational instr/rm_val to payload bundle. The stage registers its output.

Test Plan:
- Reset then instr=0xE3A010FF (MOV r1,#0xFF, rot=0), rm=X, out_ready=1 -> next cycle out_valid=1, sh_data=0x000000FF, sh_amt=0, sh_type=11, is_imm=1, rd=1.
- instr=0xE3A0140F (rot=4) -> sh_data=0x0F, sh_amt=8, sh_type=11.
- instr=0xE1A01142 (MOV r1,r2,ASR #2), rm=0x80000000 -> sh_data=0x80000000, sh_amt=2, sh_type=10, illegal=0.
- instr=0xE1A01312 (LSL by register), rm=0x1234 -> illegal=1, sh_amt=0, sh_type=00.
- Back-to-back A,B,C with out_ready low 3 cycles mid-stream -> outputs stable during stall, order A,B,C, no loss or duplication.
  - With OP2_SKID_EN: in_ready low exactly one cycle after B enters skid.
  - Without OP2_SKID_EN: in_ready low the whole stall.
- Flush asserted with in_valid=1 and a stalled entry held -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
  - Also: rst_n pulsed low mid-stall -> out_valid=0 immediately (asynchronous).
